// File: rtl/i2c_pkg.sv
// Shared I2C slave definitions: state encodings used by the read-byte,
// ACK and write-byte stages, plus default widths for the byte receiver.
package i2c_pkg;

  localparam int unsigned DEFAULT_BYTE_WIDTH   = 8;
  localparam int unsigned DEFAULT_FILTER_DEPTH = 3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RECV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/i2c_line_filter.sv
// Single-line glitch filter: the output follows the input only after DEPTH
// consecutive samples disagree with the current output. Resets to 1 (idle bus).
module i2c_line_filter
  import i2c_pkg::*;
#(
  parameter int unsigned DEPTH = DEFAULT_FILTER_DEPTH
) (
  input  logic clock,
  input  logic reset_n,
  input  logic line_in,
  output logic line_out
);

  localparam int unsigned CW = (DEPTH < 2) ? 1 : $clog2(DEPTH + 1);

  logic [CW-1:0] run;

  // Count consecutive differing samples; commit the new level on the DEPTH-th.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      line_out <= 1'b1;
      run      <= '0;
    end else if (line_in == line_out) begin
      run <= '0;
    end else if (run == CW'(DEPTH - 1)) begin
      line_out <= line_in;
      run      <= '0;
    end else begin
      run <= run + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_slave_read_byte.sv
// Slave-side byte receiver: shifts BYTE_WIDTH bits MSB first on scl rising
// edges, pulses finish with the completed byte, and pulses abort when a
// START/STOP appears mid-byte.
// Optional input glitch filtering: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave_read_byte
  import i2c_pkg::*;
#(
  parameter int unsigned BYTE_WIDTH   = DEFAULT_BYTE_WIDTH,
  parameter int unsigned FILTER_DEPTH = DEFAULT_FILTER_DEPTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  go,
  input  logic                  scl,
  input  logic                  sda,
  output logic [BYTE_WIDTH-1:0] data,
  output logic                  finish,
  output logic                  abort,
  output logic                  busy
);

  localparam int unsigned CW = $clog2(BYTE_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(BYTE_WIDTH - 1);

  logic                  scl_use;
  logic                  sda_use;
  logic                  scl_prev;
  logic                  sda_prev;
  logic                  scl_rise;
  logic                  cond;
  logic [1:0]            state;
  logic [CW-1:0]         cnt;
  logic [BYTE_WIDTH-1:0] shift_reg;
  logic [BYTE_WIDTH-1:0] shift_next;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  i2c_line_filter #(.DEPTH(FILTER_DEPTH)) u_scl_filter (
    .clock    (clock),
    .reset_n  (reset_n),
    .line_in  (scl),
    .line_out (scl_use)
  );

  i2c_line_filter #(.DEPTH(FILTER_DEPTH)) u_sda_filter (
    .clock    (clock),
    .reset_n  (reset_n),
    .line_in  (sda),
    .line_out (sda_use)
  );
`else
  assign scl_use = scl;
  assign sda_use = sda;
`endif

  // Line history for edge and START/STOP detection, tracked in every state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scl_prev <= 1'b0;
      sda_prev <= 1'b0;
    end else begin
      scl_prev <= scl_use;
      sda_prev <= sda_use;
    end
  end

  assign scl_rise   = !scl_prev && scl_use;
  assign cond       = scl_prev && scl_use && (sda_prev != sda_use);
  assign shift_next = {shift_reg[BYTE_WIDTH-2:0], sda_use};
  assign busy       = (state == ST_RECV);

  // Receive FSM: go drop beats START/STOP, which beats bit sampling.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      shift_reg <= '0;
      data      <= '0;
      finish    <= 1'b0;
      abort     <= 1'b0;
    end else begin
      finish <= 1'b0;
      abort  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (go) begin
            state <= ST_RECV;
            cnt   <= '0;
          end
        end
        ST_RECV: begin
          if (!go) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cond) begin
            abort <= 1'b1;
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (scl_rise) begin
            shift_reg <= shift_next;
            if (cnt == LAST_BIT) begin
              // Load the byte including the bit sampled on this edge.
              data   <= shift_next;
              finish <= 1'b1;
              state  <= ST_DONE;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_DONE: begin
          cnt   <= '0;
          state <= go ? ST_RECV : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_read_byte.sv
// Directed bench for i2c_slave_read_byte (scl period 20 clocks).
module tb_i2c_slave_read_byte;

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int LAT = 4;
  localparam logic [7:0] GLITCH_EXP = 8'hC3;
`else
  localparam int LAT = 1;
  localparam logic [7:0] GLITCH_EXP = 8'hC1;
`endif

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       go = 1'b0;
  logic       scl = 1'b0;
  logic       sda = 1'b1;
  logic [7:0] data;
  logic       finish;
  logic       abort;
  logic       busy;

  int total = 0;
  int bad = 0;
  int fin_cnt = 0;
  int abort_cnt = 0;
  int idle_cnt = 0;
  int f0, a0, i0;

  i2c_slave_read_byte #(.BYTE_WIDTH(8), .FILTER_DEPTH(3)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .go      (go),
    .scl     (scl),
    .sda     (sda),
    .data    (data),
    .finish  (finish),
    .abort   (abort),
    .busy    (busy)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (reset_n) begin
      if (finish) fin_cnt <= fin_cnt + 1;
      if (abort) abort_cnt <= abort_cnt + 1;
      if (!busy && !finish) idle_cnt <= idle_cnt + 1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    sda = b;
    tick(5);
    scl = 1'b1;
    tick(10);
    scl = 1'b0;
    tick(5);
  endtask

  task automatic send_bits(input logic [7:0] v, input int first, input int n);
    for (int i = first; i < first + n; i++) send_bit(v[7-i]);
  endtask

  initial begin
    tick(3);
    chk("reset_data", {24'd0, data}, 32'h0);
    chk("reset_finish", {31'd0, finish}, 32'h0);
    chk("reset_abort", {31'd0, abort}, 32'h0);
    chk("reset_busy", {31'd0, busy}, 32'h0);
    reset_n = 1'b1;
    tick(6);

    // Single byte 0xA5 with latency check on the last bit
    f0 = fin_cnt;
    go = 1'b1;
    tick(2);
    chk("busy_recv", {31'd0, busy}, 32'h1);
    send_bits(8'hA5, 0, 7);
    sda = 1'b1;
    tick(5);
    scl = 1'b1;
    tick(LAT);
    chk("a5_finish_lat", {31'd0, finish}, 32'h1);
    chk("a5_data", {24'd0, data}, 32'hA5);
    tick(1);
    chk("a5_finish_1cyc", {31'd0, finish}, 32'h0);
    tick(10 - LAT - 1);
    scl = 1'b0;
    tick(5);
    go = 1'b0;
    tick(2);
    chk("a5_busy_low", {31'd0, busy}, 32'h0);
    chk("a5_fin_count", fin_cnt - f0, 32'd1);

    // Back-to-back 0x3C, 0xFF with go held
    f0 = fin_cnt;
    go = 1'b1;
    tick(2);
    send_bits(8'h3C, 0, 8);
    chk("b2b_data0", {24'd0, data}, 32'h3C);
    i0 = idle_cnt;
    send_bits(8'hFF, 0, 8);
    chk("b2b_data1", {24'd0, data}, 32'hFF);
    chk("b2b_fin_count", fin_cnt - f0, 32'd2);
    chk("b2b_no_idle", idle_cnt - i0, 32'd0);
    go = 1'b0;
    tick(2);

    // START mid-byte after 4 bits of 0xF0
    f0 = fin_cnt;
    a0 = abort_cnt;
    go = 1'b1;
    tick(2);
    send_bits(8'hF0, 0, 3);
    sda = 1'b1;
    tick(5);
    scl = 1'b1;
    tick(5);
    sda = 1'b0;
    tick(LAT);
    chk("abort_pulse", {31'd0, abort}, 32'h1);
    chk("abort_no_finish", {31'd0, finish}, 32'h0);
    chk("abort_idle", {31'd0, busy}, 32'h0);
    tick(1);
    chk("abort_1cyc", {31'd0, abort}, 32'h0);
    go = 1'b0;
    scl = 1'b0;
    tick(5);
    sda = 1'b1;
    tick(5);
    chk("abort_data_kept", {24'd0, data}, 32'hFF);
    chk("abort_fin_count", fin_cnt - f0, 32'd0);
    chk("abort_count", abort_cnt - a0, 32'd1);

    // go dropped after 5 bits, then 0x81
    f0 = fin_cnt;
    a0 = abort_cnt;
    go = 1'b1;
    tick(2);
    send_bits(8'hE7, 0, 5);
    go = 1'b0;
    tick(1);
    chk("godrop_busy", {31'd0, busy}, 32'h0);
    tick(4);
    chk("godrop_no_fin", fin_cnt - f0, 32'd0);
    chk("godrop_no_abort", abort_cnt - a0, 32'd0);
    go = 1'b1;
    tick(2);
    send_bits(8'h81, 0, 8);
    chk("godrop_data81", {24'd0, data}, 32'h81);
    chk("godrop_fin_count", fin_cnt - f0, 32'd1);
    go = 1'b0;
    tick(2);

    // Reset after 6 bits, then 0x55
    go = 1'b1;
    tick(2);
    send_bits(8'hC9, 0, 6);
    reset_n = 1'b0;
    go = 1'b0;
    sda = 1'b1;
    #1;
    chk("rst_mid_data", {24'd0, data}, 32'h0);
    chk("rst_mid_finish", {31'd0, finish}, 32'h0);
    chk("rst_mid_abort", {31'd0, abort}, 32'h0);
    chk("rst_mid_busy", {31'd0, busy}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(6);
    f0 = fin_cnt;
    go = 1'b1;
    tick(2);
    send_bits(8'h55, 0, 8);
    chk("rst_data55", {24'd0, data}, 32'h55);
    chk("rst_fin_count", fin_cnt - f0, 32'd1);
    go = 1'b0;
    tick(2);

    // 2-clock scl glitch in the third bit of 0xC3
    f0 = fin_cnt;
    go = 1'b1;
    tick(2);
    send_bits(8'hC3, 0, 2);
    sda = 1'b0;
    tick(2);
    scl = 1'b1;
    tick(2);
    scl = 1'b0;
    tick(3);
    scl = 1'b1;
    tick(10);
    scl = 1'b0;
    tick(5);
    send_bits(8'hC3, 3, 5);
    chk("glitch_data", {24'd0, data}, {24'd0, GLITCH_EXP});
    chk("glitch_fin_count", fin_cnt - f0, 32'd1);
    go = 1'b0;
    tick(2);
    chk("final_busy", {31'd0, busy}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_slave_read_byte.md
Name: i2c_slave_read_byte

Overview:
Slave-side byte receiver. It assembles BYTE_WIDTH bits from the I2C bus, MSB first, and sends the byte to the slave controller FSM with a one-cycle finish strobe. It samples sda on each detected scl rising edge and watches for START/STOP conditions mid-byte. It sits between the bus pins and the slave controller; the ACK write stage follows it.

Parameters:
BYTE_WIDTH, 8, number of bits per transfer (MSB received first)
FILTER_DEPTH, 3, consecutive equal samples required by the optional glitch filter (only used with I2C_SLAVE_GLITCH_FILTER_EN)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
go  input  1  level enable from controller; held high for the whole byte
scl  input  1  I2C clock line, synchronous to clock
sda  input  1  I2C data line, synchronous to clock
data  output  BYTE_WIDTH  received byte; updated only with finish
finish  output  1  one-cycle pulse: data valid
abort  output  1  one-cycle pulse: START/STOP seen mid-byte, byte discarded
busy  output  1  high while in RECV state

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clock. On reset, all outputs are 0. Internal state is IDLE, bit counter 0, shift register 0, scl/sda history 0.
- Edge detection:
  - scl_prev and sda_prev are registered every clock, regardless of state.
  - scl_rise = !scl_prev && scl (current input).
  - cond = scl_prev && scl && (sda_prev != sda). This is a START or STOP condition.
- State IDLE:
  - busy=0.
  - go=1 moves to RECV next cycle with counter cleared.
  - No sampling happens in the go-assert cycle.
- State RECV:
  - busy=1.
  - Priority, highest first: go=0, then cond, then scl_rise.
  - go=0: return to IDLE, clear counter, no finish, no abort.
  - cond: abort=1 next cycle, return to IDLE, clear counter. data is unchanged.
  - scl_rise: shift_reg <= {shift_reg[BYTE_WIDTH-2:0], sda}; counter++.
  - On the rise where counter==BYTE_WIDTH-1, go to DONE. data loads the completed byte, including the current sda bit.
- State DONE (one cycle):
  - finish=1 and data is valid.
  - Next state is RECV if go=1 (back-to-back bytes) or IDLE if go=0.
  - Counter is cleared.
- finish and abort are registered and never asserted in the same cycle.
- data holds its last value until the next finish. It is never cleared except by reset.
- Latency: finish rises exactly one clock after the clock edge on which the last scl_rise is sampled.
- scl high before go: the first bit requires a fresh rising edge. A bus already high on entry does not sample.
- cond on the same cycle as scl_rise is impossible by construction, because cond requires scl_prev=1.
- Reset mid-byte: the async clear takes effect immediately with no finish pulse.

Optional Feature:
I2C_SLAVE_GLITCH_FILTER_EN.
- Defined: scl and sda each pass through a filter that updates its output only after FILTER_DEPTH consecutive identical samples. Edge and cond detection use the filtered values. This adds FILTER_DEPTH cycles of input latency, and pulses shorter than FILTER_DEPTH clocks are ignored. Filter outputs reset to 1 (bus idle).
- Undefined: raw scl/sda are used directly. Inputs are already synchronized upstream.

Decomposition:
- Shared package i2c_pkg holds:
  - state encoding localparams (ST_IDLE, ST_RECV, ST_DONE), shared with the ACK and write-byte stages;
  - default BYTE_WIDTH;
  - default FILTER_DEPTH.
- Sub-module i2c_line_filter: a single-line glitch filter, instantiated twice (scl, sda), only under the macro.
- Edge detection stays inline.

Test Plan:
- go=1, drive byte 0xA5 MSB-first with scl period 20 clocks -> exactly one finish pulse, data=0xA5, asserted 1 clock after the 8th scl rise; busy low afterwards with go=0.
- go held high, two bytes 0x3C then 0xFF back-to-back -> two finish pulses with data 0x3C then 0xFF, and no IDLE visit between them.
- After 4 bits of 0xF0, sda falls while scl is high (START) -> abort=1 for one cycle, no finish, data keeps its previous value, state IDLE.
- Deassert go after 5 bits -> no finish and no abort; a following go with byte 0x81 yields data=0x81, proving the counter was cleared.
- Assert reset_n=0 mid-byte after 6 bits -> all outputs 0 immediately; after release, a full byte 0x55 is received correctly.
- With I2C_SLAVE_GLITCH_FILTER_EN, FILTER_DEPTH=3, inject a 2-clock scl high glitch during a bit -> no extra bit sampled and byte 0xC3 is received intact; without the macro, the same glitch shifts in a spurious bit.
